// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x DATA_W register file with one write port, two
// registered read ports (write-first bypass) and per-register valid/busy bits.
module regfile_2r1w #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          writenum,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       reserve,
  input  logic [ADDR_W-1:0]          resnum,
  input  logic [ADDR_W-1:0]          readnum_a,
  input  logic [ADDR_W-1:0]          readnum_b,
  output logic [DATA_W-1:0]          data_out_a,
  output logic [DATA_W-1:0]          data_out_b,
  output logic                       valid_a,
  output logic                       valid_b,
  output logic                       busy_a,
  output logic                       busy_b,
  output logic [(1 << ADDR_W)-1:0]   busy_mask
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs     [NREGS];
  logic [NREGS-1:0]  r_valid;
  logic [NREGS-1:0]  r_busy;

  logic [DATA_W-1:0] w_regs_nxt [NREGS];
  logic [NREGS-1:0]  w_valid_nxt;
  logic [NREGS-1:0]  w_busy_nxt;

  // Post-update state; reserve is applied after write so it wins on a tie.
  always_comb begin
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    for (int unsigned i = 0; i < NREGS; i++) begin
      w_regs_nxt[i] = r_regs[i];
      if (write && (writenum == ADDR_W'(i))) begin
        w_regs_nxt[i]  = data_in;
        w_valid_nxt[i] = 1'b1;
        w_busy_nxt[i]  = 1'b0;
      end
      if (reserve && (resnum == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
    if (ZERO_R0 != 0) begin
      w_regs_nxt[0]  = '0;
      w_valid_nxt[0] = 1'b1;
      w_busy_nxt[0]  = 1'b0;
    end
  end

  // Storage update and registered read ports sourced from post-update state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_valid    <= '0;
      r_busy     <= '0;
      data_out_a <= '0;
      data_out_b <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      busy_a     <= 1'b0;
      busy_b     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= w_regs_nxt[i];
      end
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      data_out_a <= w_regs_nxt[readnum_a];
      data_out_b <= w_regs_nxt[readnum_b];
      valid_a    <= w_valid_nxt[readnum_a];
      valid_b    <= w_valid_nxt[readnum_b];
      busy_a     <= w_busy_nxt[readnum_a];
      busy_b     <= w_busy_nxt[readnum_b];
    end
  end

  // Busy bits exposed directly from state for the stall logic.
  assign busy_mask = r_busy;

endmodule
